// File: rtl/fp32_mul_pkg.sv
// Shared constants and the S1->S2 stage record for the FP32 multiplier
// round/pack stage.
package fp32_mul_pkg;

    localparam int          BIAS    = 127;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    // FP32 field positions
    localparam int SIGN    = 31;
    localparam int EXP_HI  = 30;
    localparam int EXP_LO  = 23;
    localparam int MANT_HI = 22;
    localparam int MANT_LO = 0;

    // Result class resolved in S1, in priority order NAN > INF > ZERO > NORM
    typedef enum logic [1:0] {
        SC_NORM = 2'd0,
        SC_NAN  = 2'd1,
        SC_INF  = 2'd2,
        SC_ZERO = 2'd3
    } sclass_t;

    // S1 -> S2 record; esum is a 10-bit two's-complement biased exponent
    typedef struct packed {
        logic        valid;
        logic        sign;
        logic [9:0]  esum;
        logic [6:0]  mant7;
        logic        g;
        logic        r;
        logic        s;
        sclass_t     sclass;
    } s1_rec_t;

endpackage

// File: rtl/fp32_classify.sv
// Combinational operand classifier. Exponent 0 (zero or denormal) is
// reported as zero because the multiplier flushes denormals.
module fp32_classify
    import fp32_mul_pkg::*;
(
    input  logic [31:0] i_op,
    output logic        o_is_nan,
    output logic        o_is_inf,
    output logic        o_is_zero
);

    logic w_exp_max;
    logic w_mant_nz;

    assign w_exp_max = &i_op[EXP_HI:EXP_LO];
    assign w_mant_nz = |i_op[MANT_HI:MANT_LO];

    assign o_is_nan  = w_exp_max &  w_mant_nz;
    assign o_is_inf  = w_exp_max & ~w_mant_nz;
    assign o_is_zero = ~|i_op[EXP_HI:EXP_LO];

endmodule

// File: rtl/fp32_mul_round_pack.sv
// Round/pack stage for the 8-bit-mantissa approximate FP32 multiplier.
// Two-stage valid/ready pipeline: S1 classifies and normalises, S2 rounds
// (nearest-even), range-checks and packs into the output register.
// Optional build macro FP_MUL_FLAGS_EN adds the out_flags port
// {invalid, overflow, underflow, inexact}, registered alongside out_y.
module fp32_mul_round_pack
    import fp32_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [15:0] in_prod,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y
`ifdef FP_MUL_FLAGS_EN
    ,
    output logic [3:0]  out_flags
`endif
);

    s1_rec_t     r_s1;
    s1_rec_t     w_s1_nxt;
    logic        r_s2_valid;
    logic [31:0] r_y;
    logic        w_s2_adv;

    logic        w_nan_a, w_inf_a, w_zero_a;
    logic        w_nan_b, w_inf_b, w_zero_b;

    logic        w_up;
    logic [7:0]  w_m8;
    logic [9:0]  w_e;
    logic        w_ovf;
    logic        w_unf;
    logic [31:0] w_y;

    // S2 moves when it is empty or its result is being taken; S1 may load
    // while S2 is stalled as long as S1 itself is empty.
    assign w_s2_adv  = !r_s2_valid | out_ready;
    assign in_ready  = !r_s1.valid | w_s2_adv;
    assign out_valid = r_s2_valid;
    assign out_y     = r_y;

    fp32_classify u_cls_a (
        .i_op      (in_a),
        .o_is_nan  (w_nan_a),
        .o_is_inf  (w_inf_a),
        .o_is_zero (w_zero_a)
    );

    fp32_classify u_cls_b (
        .i_op      (in_b),
        .o_is_nan  (w_nan_b),
        .o_is_inf  (w_inf_b),
        .o_is_zero (w_zero_b)
    );

    // S1: sign, exponent sum, normalisation of the raw product and class
    always_comb begin
        w_s1_nxt       = '0;
        w_s1_nxt.valid = 1'b1;
        w_s1_nxt.sign  = in_a[SIGN] ^ in_b[SIGN];
        w_s1_nxt.esum  = {2'b00, in_a[EXP_HI:EXP_LO]} + {2'b00, in_b[EXP_HI:EXP_LO]}
                       - 10'(BIAS);
        if (in_prod[15]) begin
            w_s1_nxt.mant7 = in_prod[14:8];
            w_s1_nxt.g     = in_prod[7];
            w_s1_nxt.r     = in_prod[6];
            w_s1_nxt.s     = |in_prod[5:0];
            w_s1_nxt.esum  = w_s1_nxt.esum + 10'd1;
        end else begin
            // Taken even if prod[14] is 0: the approximate core can emit
            // such products and they are packed without a further shift.
            w_s1_nxt.mant7 = in_prod[13:7];
            w_s1_nxt.g     = in_prod[6];
            w_s1_nxt.r     = in_prod[5];
            w_s1_nxt.s     = |in_prod[4:0];
        end
        if (w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_inf_b & w_zero_a))
            w_s1_nxt.sclass = SC_NAN;
        else if (w_inf_a | w_inf_b)
            w_s1_nxt.sclass = SC_INF;
        else if (w_zero_a | w_zero_b)
            w_s1_nxt.sclass = SC_ZERO;
        else
            w_s1_nxt.sclass = SC_NORM;
    end

    // S1 register: capture a beat on accept, drop valid when it moves on
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= '0;
        end else if (in_ready) begin
            if (in_valid)
                r_s1 <= w_s1_nxt;
            else
                r_s1.valid <= 1'b0;
        end
    end

    // S2: round to nearest even, range check and pack
    always_comb begin
        w_up  = r_s1.g & (r_s1.r | r_s1.s | r_s1.mant7[0]);
        w_m8  = {1'b0, r_s1.mant7} + {7'd0, w_up};
        // On carry-out the low 7 bits are already zero (1.1111111 + ulp = 10.0)
        w_e   = r_s1.esum + {9'd0, w_m8[7]};
        w_ovf = $signed(w_e) >= 10'sd255;
        w_unf = $signed(w_e) <= 10'sd0;
        w_y   = {r_s1.sign, w_e[7:0], w_m8[6:0], 16'd0};
        case (r_s1.sclass)
            SC_NAN:  w_y = QNAN;
            SC_INF:  w_y = {r_s1.sign, 8'hFF, 23'd0};
            SC_ZERO: w_y = {r_s1.sign, 31'd0};
            default: begin
                if (w_ovf)
                    w_y = {r_s1.sign, 8'hFF, 23'd0};
                else if (w_unf)
                    w_y = {r_s1.sign, 31'd0};
            end
        endcase
    end

    // S2 / output register: holds its result while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_y        <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1.valid;
            if (r_s1.valid)
                r_y <= w_y;
        end
    end

`ifdef FP_MUL_FLAGS_EN
    logic [3:0] w_flags;
    logic [3:0] r_flags;

    // Flags {invalid, overflow, underflow, inexact}; special results other
    // than NaN are exact
    always_comb begin
        w_flags = '0;
        case (r_s1.sclass)
            SC_NAN:  w_flags = 4'b1000;
            SC_NORM: w_flags = {1'b0, w_ovf, w_unf,
                                w_ovf | w_unf | r_s1.g | r_s1.r | r_s1.s};
            default: w_flags = '0;
        endcase
    end

    // Flag register, loaded in lockstep with out_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_flags <= '0;
        else if (w_s2_adv && r_s1.valid)
            r_flags <= w_flags;
    end

    assign out_flags = r_flags;
`endif

endmodule
